mmio_bridge: RTL and testbench

MMIO_BRIDGE -- requirements
Module: mmio_bridge

---
 rtl/mmio_pkg.sv | 17 +
 rtl/mmio_addr_decode.sv | 38 +++
 rtl/mmio_bridge.sv | 217 +++++++++++++++++++++
 tb/tb_mmio_bridge.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared definitions for the MMIO bridge.
//   - mmio_state_e      : bridge FSM states (IDLE, ACCESS, RESP)
//   - MMIO_BASE_DEFAULT : default start address of the MMIO window
//   - MMIO_ERR_DATA     : all-ones read data returned on an access error,
//                         sliced to DATA_W by the user (DATA_W <= 64)
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } mmio_state_e;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h1000_0000;
  localparam logic [63:0] MMIO_ERR_DATA     = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/mmio_addr_decode.sv
// mmio_addr_decode: combinational window/channel decode for the MMIO bridge.
// Ports:
//   addr (in, ADDR_W) : core access address
//   hit  (out, 1)     : BASE <= addr <= BASE + (NUM_CH << CH_SPAN_LOG2) - 1
//   ch   (out, CH_W)  : (addr - BASE) >> CH_SPAN_LOG2, meaningful only on hit
module mmio_addr_decode
  import mmio_pkg::*;
#(
  parameter int                 NUM_CH       = 4,
  parameter int                 ADDR_W       = 32,
  parameter logic [ADDR_W-1:0]  BASE         = ADDR_W'(MMIO_BASE_DEFAULT),
  parameter int                 CH_SPAN_LOG2 = 16,
  parameter int                 CH_W         = 2
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [CH_W-1:0]   ch
);

  // One extra bit so the window end cannot wrap when BASE sits near the top
  // of the address space.
  localparam logic [ADDR_W:0] WIN_SPAN = (ADDR_W + 1)'(NUM_CH) << CH_SPAN_LOG2;
  localparam logic [ADDR_W:0] BASE_X   = {1'b0, BASE};

  logic [ADDR_W:0] addr_x_s;
  logic [ADDR_W:0] off_s;
  logic            above_s;

  // Window compare and channel extraction
  always_comb begin
    addr_x_s = {1'b0, addr};
    off_s    = addr_x_s - BASE_X;
    above_s  = (addr_x_s >= BASE_X);
    hit      = above_s && (off_s < WIN_SPAN);
    ch       = off_s[CH_SPAN_LOG2 +: CH_W];
  end

endmodule

// File: rtl/mmio_bridge.sv
// mmio_bridge: stalls the core memory stage while one access is forwarded to
// one of NUM_CH peripheral channels on a shared bus.
// Optional feature: define MMIO_TIMEOUT_EN to abort an ACCESS that has seen
// no ready after TIMEOUT_CYC cycles (response with m_err=1, all-ones data).
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   m_req/m_wr/m_addr/m_wdata : core request
//   m_stall             : freeze request to the core pipeline
//   m_rdata/m_rvalid/m_err    : response, valid in the RESP cycle
//   p_cs/p_wr/p_rd/p_addr/p_wdata : shared peripheral bus, one-hot select
//   p_rdata/p_ready     : per-channel read data and completion
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int                NUM_CH       = 4,
  parameter int                ADDR_W       = 32,
  parameter int                DATA_W       = 32,
  parameter logic [ADDR_W-1:0] BASE         = ADDR_W'(MMIO_BASE_DEFAULT),
  parameter int                CH_SPAN_LOG2 = 16,
  parameter int                TIMEOUT_CYC  = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     m_req,
  input  logic                     m_wr,
  input  logic [ADDR_W-1:0]        m_addr,
  input  logic [DATA_W-1:0]        m_wdata,
  output logic                     m_stall,
  output logic [DATA_W-1:0]        m_rdata,
  output logic                     m_rvalid,
  output logic                     m_err,
  output logic [NUM_CH-1:0]        p_cs,
  output logic                     p_wr,
  output logic                     p_rd,
  output logic [ADDR_W-1:0]        p_addr,
  output logic [DATA_W-1:0]        p_wdata,
  input  logic [NUM_CH*DATA_W-1:0] p_rdata,
  input  logic [NUM_CH-1:0]        p_ready
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  mmio_state_e       state_r;
  mmio_state_e       state_next_s;

  logic              hit_s;
  logic [CH_W-1:0]   ch_s;

  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] rdata_r;
  logic              wr_r;
  logic [CH_W-1:0]   ch_r;

  logic              accept_s;
  logic              capture_s;
  logic              timeout_s;
  logic              abort_s;
  logic              stall_s;
  logic              ready_sel_s;
  logic [DATA_W-1:0] rdata_sel_s;

  mmio_addr_decode #(
    .NUM_CH       (NUM_CH),
    .ADDR_W       (ADDR_W),
    .BASE         (BASE),
    .CH_SPAN_LOG2 (CH_SPAN_LOG2),
    .CH_W         (CH_W)
  ) u_decode (
    .addr (m_addr),
    .hit  (hit_s),
    .ch   (ch_s)
  );

  // Only the latched channel's ready and data matter; the rest are ignored
  always_comb begin
    ready_sel_s = p_ready[ch_r];
    rdata_sel_s = p_rdata[int'(ch_r) * DATA_W +: DATA_W];
  end

`ifdef MMIO_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_r;
  logic             err_r;

  // ACCESS-cycle counter, cleared on every entry to ACCESS
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (accept_s) begin
      cnt_r <= '0;
    end else if (state_r == ACCESS) begin
      cnt_r <= cnt_r + CNT_W'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // The counter holds the number of completed ACCESS cycles, so the last
  // permitted cycle is when it reads TIMEOUT_CYC-1.
  assign timeout_s = (cnt_r == CNT_W'(TIMEOUT_CYC - 1));

  // Error flag for the coming RESP cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (capture_s) begin
      err_r <= 1'b0;
    end else if (abort_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign m_err = (state_r == RESP) && err_r;
`else
  assign timeout_s = 1'b0;
  assign m_err     = 1'b0;
`endif

  // Next-state and handshake decode
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    capture_s    = 1'b0;
    abort_s      = 1'b0;
    stall_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (m_req && hit_s) begin
          accept_s     = 1'b1;
          stall_s      = 1'b1;
          state_next_s = ACCESS;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACCESS: begin
        stall_s = 1'b1;
        if (ready_sel_s) begin
          capture_s    = 1'b1;
          state_next_s = RESP;
        end else if (timeout_s) begin
          abort_s      = 1'b1;
          state_next_s = RESP;
        end else begin
          state_next_s = ACCESS;
        end
      end
      RESP: begin
        // Any m_req seen here is left for the following IDLE cycle
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Request latch on accept; response data on completion or abort
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_r  <= '0;
      wdata_r <= '0;
      wr_r    <= 1'b0;
      ch_r    <= '0;
      rdata_r <= '0;
    end else begin
      if (accept_s) begin
        addr_r  <= m_addr;
        wdata_r <= m_wdata;
        wr_r    <= m_wr;
        ch_r    <= ch_s;
      end
      if (capture_s) begin
        rdata_r <= rdata_sel_s;
      end else if (abort_s) begin
        rdata_r <= MMIO_ERR_DATA[DATA_W-1:0];
      end
    end
  end

  // Bus and response strobes decoded from registered state only
  always_comb begin
    p_cs     = '0;
    p_wr     = 1'b0;
    p_rd     = 1'b0;
    m_rvalid = 1'b0;
    if (state_r == ACCESS) begin
      p_cs[ch_r] = 1'b1;
      p_wr       = wr_r;
      p_rd       = ~wr_r;
    end else if (state_r == RESP) begin
      m_rvalid = ~wr_r;
    end else begin
      p_cs = '0;
    end
  end

  // Stall is combinational on accept; reset must drop it at once
  assign m_stall = stall_s & ~reset;
  assign m_rdata = rdata_r;
  assign p_addr  = addr_r;
  assign p_wdata = wdata_r;

endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge. Stimulus pushes expected bus accesses
// and responses into queues; a negedge monitor pops and compares them.
module tb_mmio_bridge;

  logic         clk;
  logic         reset;
  logic         m_req;
  logic         m_wr;
  logic [31:0]  m_addr;
  logic [31:0]  m_wdata;
  logic         m_stall;
  logic [31:0]  m_rdata;
  logic         m_rvalid;
  logic         m_err;
  logic [3:0]   p_cs;
  logic         p_wr;
  logic         p_rd;
  logic [31:0]  p_addr;
  logic [31:0]  p_wdata;
  logic [127:0] p_rdata;
  logic [3:0]   p_ready;

  mmio_bridge dut (
    .clk      (clk),
    .reset    (reset),
    .m_req    (m_req),
    .m_wr     (m_wr),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_stall  (m_stall),
    .m_rdata  (m_rdata),
    .m_rvalid (m_rvalid),
    .m_err    (m_err),
    .p_cs     (p_cs),
    .p_wr     (p_wr),
    .p_rd     (p_rd),
    .p_addr   (p_addr),
    .p_wdata  (p_wdata),
    .p_rdata  (p_rdata),
    .p_ready  (p_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Peripheral model: channel i answers on its ready_after[i]-th ACCESS
  // cycle (0 = never); unselected channels show noise_ready.
  int          ready_after [4];
  logic [31:0] ch_data     [4];
  logic [3:0]  noise_ready;
  int          acc_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset)            acc_cnt <= 0;
    else if (p_cs != 4'd0) acc_cnt <= acc_cnt + 1;
    else                  acc_cnt <= 0;
  end

  always_comb begin
    p_rdata = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};
    p_ready = 4'd0;
    for (int i = 0; i < 4; i++) begin
      if (p_cs[i]) p_ready[i] = (ready_after[i] != 0) && (acc_cnt + 1 >= ready_after[i]);
      else         p_ready[i] = noise_ready[i];
    end
  end

  typedef struct {
    logic [3:0]  cs;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          len;
  } acc_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  acc_t acc_q[$];
  rsp_t rsp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: bus pulses against acc_q, responses against rsp_q
  acc_t cur;
  bit   in_pulse = 1'b0;
  int   plen     = 0;

  always @(negedge clk) begin
    rsp_t r;
    if (p_cs != 4'd0) begin
      if (!in_pulse) begin
        if (acc_q.size() == 0) begin
          check(1'b0, "unexpected_access", {60'd0, p_cs}, 64'd0);
        end else begin
          cur      = acc_q.pop_front();
          in_pulse = 1'b1;
          plen     = 0;
        end
      end
      if (in_pulse) begin
        plen++;
        check({p_cs, p_wr, p_rd} === {cur.cs, cur.wr, ~cur.wr}, "bus_ctrl",
              {58'd0, p_cs, p_wr, p_rd}, {58'd0, cur.cs, cur.wr, ~cur.wr});
        check(p_addr === cur.addr, "bus_addr", {32'd0, p_addr}, {32'd0, cur.addr});
        if (cur.wr) check(p_wdata === cur.wdata, "bus_wdata", {32'd0, p_wdata}, {32'd0, cur.wdata});
      end
    end else if (in_pulse) begin
      in_pulse = 1'b0;
      check(plen == cur.len, "cs_pulse_len", 64'(plen), 64'(cur.len));
    end
    if (m_rvalid || m_err) begin
      if (rsp_q.size() == 0) begin
        check(1'b0, "unexpected_response", {31'd0, m_err, m_rdata}, 64'd0);
      end else begin
        r = rsp_q.pop_front();
        check({m_rvalid, m_err, m_rdata} === {1'b1, r.err, r.rdata}, "response",
              {31'd0, m_err, m_rdata}, {31'd0, r.err, r.rdata});
      end
    end
  end

  // One core access; counts stall cycles and checks m_rvalid when the stall
  // drops. Request inputs are scrambled during ACCESS and must be ignored.
  task automatic do_access(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                           input int exp_stall, input logic exp_rvalid, input string name);
    int  n    = 0;
    bit  done = 1'b0;
    @(posedge clk); #1;
    m_req = 1'b1; m_addr = addr; m_wr = wr; m_wdata = wdata;
    for (int i = 0; i < 400 && !done; i++) begin
      #2;
      if (m_stall) begin
        n++;
      end else begin
        done = 1'b1;
        check(m_rvalid === exp_rvalid, {name, "_rvalid"}, {63'd0, m_rvalid}, {63'd0, exp_rvalid});
      end
      if (!done) begin
        @(posedge clk); #1;
        if (i == 0) begin
          m_addr = 32'h1001_0000; m_wr = ~wr; m_wdata = 32'hDEAD_BEEF;
        end
      end
    end
    m_req = 1'b0;
    check(done, {name, "_stall_bound"}, {63'd0, done}, 64'd1);
    check(n == exp_stall, {name, "_stall_cycles"}, 64'(n), 64'(exp_stall));
  endtask

  logic [3:0] bb_cs    [6];
  logic       bb_stall [6];

  initial begin
    reset = 1'b1; m_req = 1'b0; m_wr = 1'b0; m_addr = 32'd0; m_wdata = 32'd0;
    noise_ready = 4'd0;
    for (int i = 0; i < 4; i++) begin ready_after[i] = 1; ch_data[i] = 32'd0; end

    // Reset state
    @(posedge clk); #1;
    check({m_stall, m_rvalid, m_err, p_cs, p_wr, p_rd} === 9'd0, "reset_ctrl",
          {55'd0, m_stall, m_rvalid, m_err, p_cs, p_wr, p_rd}, 64'd0);
    check({m_rdata, p_addr} === 64'd0, "reset_data", {m_rdata, p_addr}, 64'd0);
    check(p_wdata === 32'd0, "reset_wdata", {32'd0, p_wdata}, 64'd0);
    @(posedge clk); #1; reset = 1'b0;

    // Read ch0, immediate ready: 2 stall cycles, rvalid on cycle 3
    ch_data[0] = 32'hA5A5_0001;
    acc_q.push_back('{4'b0001, 1'b0, 32'h1000_0004, 32'd0, 1});
    rsp_q.push_back('{32'hA5A5_0001, 1'b0});
    do_access(32'h1000_0004, 1'b0, 32'd0, 2, 1'b1, "rd_ch0");

    // Write ch3, ready on 5th ACCESS cycle; other channels' ready ignored
    ready_after[3] = 5; noise_ready = 4'b0111;
    acc_q.push_back('{4'b1000, 1'b1, 32'h1003_0010, 32'h0000_00FF, 5});
    do_access(32'h1003_0010, 1'b1, 32'h0000_00FF, 6, 1'b0, "wr_ch3");
    noise_ready = 4'd0; ready_after[3] = 1;

    // Window boundaries
    do_access(32'h2000_0000, 1'b0, 32'd0, 0, 1'b0, "miss_hi");
    do_access(32'h1004_0000, 1'b0, 32'd0, 0, 1'b0, "miss_end");
    do_access(32'h0FFF_FFFC, 1'b0, 32'd0, 0, 1'b0, "miss_lo");
    ch_data[3] = 32'h3333_CAFE;
    acc_q.push_back('{4'b1000, 1'b0, 32'h1003_FFFC, 32'd0, 1});
    rsp_q.push_back('{32'h3333_CAFE, 1'b0});
    do_access(32'h1003_FFFC, 1'b0, 32'd0, 2, 1'b1, "rd_last");

    // Reset on the 2nd ACCESS cycle, request held high throughout
    ready_after[1] = 3;
    acc_q.push_back('{4'b0010, 1'b0, 32'h1001_0008, 32'd0, 1});
    @(posedge clk); #1; m_req = 1'b1; m_addr = 32'h1001_0008; m_wr = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1'b1; #1;
    check({m_stall, m_rvalid, m_err, p_cs, p_wr, p_rd} === 9'd0, "midreset_ctrl",
          {55'd0, m_stall, m_rvalid, m_err, p_cs, p_wr, p_rd}, 64'd0);
    check({m_rdata, p_addr} === 64'd0, "midreset_data", {m_rdata, p_addr}, 64'd0);
    @(posedge clk); #1; m_req = 1'b0; reset = 1'b0;
    ready_after[1] = 1; ch_data[1] = 32'h1111_2222;
    acc_q.push_back('{4'b0010, 1'b0, 32'h1001_0008, 32'd0, 1});
    rsp_q.push_back('{32'h1111_2222, 1'b0});
    do_access(32'h1001_0008, 1'b0, 32'd0, 2, 1'b1, "after_reset");

    // Back-to-back reads with m_req held through RESP
    bb_cs    = '{4'd0, 4'b0100, 4'd0, 4'd0, 4'b0100, 4'd0};
    bb_stall = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    ch_data[2] = 32'hC0DE_0001;
    acc_q.push_back('{4'b0100, 1'b0, 32'h1002_0000, 32'd0, 1});
    acc_q.push_back('{4'b0100, 1'b0, 32'h1002_0000, 32'd0, 1});
    rsp_q.push_back('{32'hC0DE_0001, 1'b0});
    rsp_q.push_back('{32'hC0DE_0002, 1'b0});
    @(posedge clk); #1; m_req = 1'b1; m_addr = 32'h1002_0000; m_wr = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #2;
      check({p_cs, m_stall} === {bb_cs[c], bb_stall[c]}, $sformatf("b2b_cycle%0d", c),
            {59'd0, p_cs, m_stall}, {59'd0, bb_cs[c], bb_stall[c]});
      if (c == 2) ch_data[2] = 32'hC0DE_0002;
      if (c == 5) m_req = 1'b0;
      else begin @(posedge clk); #1; end
    end

`ifdef MMIO_TIMEOUT_EN
    // Timeout: no ready on ch3 -> error response after 255 ACCESS cycles
    ready_after[3] = 0;
    acc_q.push_back('{4'b1000, 1'b0, 32'h1003_0000, 32'd0, 255});
    rsp_q.push_back('{32'hFFFF_FFFF, 1'b1});
    do_access(32'h1003_0000, 1'b0, 32'd0, 256, 1'b1, "timeout");
    ready_after[3] = 1;
`endif

    repeat (3) @(posedge clk);
    #1;
    check(acc_q.size() == 0 && !in_pulse, "acc_queue_drained", 64'(acc_q.size()), 64'd0);
    check(rsp_q.size() == 0, "rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
